// File: rtl/cpu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer with memory handshakes,
// retire counter and a sticky trap on illegal instructions or memory timeouts.
module cpu_sequencer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    input  logic        reg_write,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        mem_to_reg,
    input  logic        branch,
    input  logic        jump,
    input  logic        jump_reg,
    input  logic        illegal,
    input  logic        alu_zero,
    output logic        imem_req,
    output logic        ir_write,
    output logic        alu_en,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        rf_write,
    output logic        wb_sel,
    output logic        pc_write,
    output logic [1:0]  pc_sel,
    output logic [31:0] retired,
    output logic [2:0]  state,
    output logic        trap
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6,
        S_BAD    = 3'd7
    } state_t;

    localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT - 32'd1);

    state_t      state_r;
    state_t      next_s;
    logic [7:0]  wait_cnt_r;
    logic [31:0] retired_r;
    logic        taken_r;
    logic        jr_r;
    logic        mem_read_r;
    logic        mem_write_r;
    logic        mem_to_reg_r;
    logic        retire_s;
    logic        at_limit_s;
    logic        sel_taken_s;
    logic        sel_jr_s;

    assign at_limit_s = (wait_cnt_r == WAIT_LIMIT);
    assign state      = state_r;
    assign retired    = retired_r;

    // Next-state and strobe decode from the current state.
    always_comb begin
        next_s   = state_r;
        retire_s = 1'b0;
        imem_req = 1'b0;
        ir_write = 1'b0;
        alu_en   = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        rf_write = 1'b0;
        wb_sel   = 1'b0;
        trap     = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    next_s = S_FETCH;
                end else begin
                    next_s = S_IDLE;
                end
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_write = 1'b1;
                    next_s   = S_DECODE;
                end else if (at_limit_s) begin
                    next_s = S_TRAP;
                end else begin
                    next_s = S_FETCH;
                end
            end
            S_DECODE: begin
                if (illegal || (mem_read && mem_write)) begin
                    next_s = S_TRAP;
                end else begin
                    next_s = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_en = 1'b1;
                if (mem_read || mem_write) begin
                    next_s = S_MEM;
                end else if (reg_write) begin
                    next_s = S_WB;
                end else begin
                    retire_s = 1'b1;
                    next_s   = S_FETCH;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = mem_write_r;
                if (dmem_ready) begin
                    if (mem_read_r) begin
                        next_s = S_WB;
                    end else begin
                        retire_s = 1'b1;
                        next_s   = S_FETCH;
                    end
                end else if (at_limit_s) begin
                    next_s = S_TRAP;
                end else begin
                    next_s = S_MEM;
                end
            end
            S_WB: begin
                rf_write = 1'b1;
                wb_sel   = mem_to_reg_r;
                retire_s = 1'b1;
                next_s   = S_FETCH;
            end
            S_TRAP: begin
                trap   = 1'b1;
                next_s = S_TRAP;
            end
            default: begin
                next_s = S_TRAP;
            end
        endcase
    end

    // A retire straight out of EXEC has not registered taken/jr yet, so use the live terms.
    always_comb begin
        if (state_r == S_EXEC) begin
            sel_taken_s = (branch && alu_zero) || jump || jump_reg;
            sel_jr_s    = jump_reg;
        end else begin
            sel_taken_s = taken_r;
            sel_jr_s    = jr_r;
        end
        pc_write = retire_s;
        if (!retire_s) begin
            pc_sel = 2'd0;
        end else if (sel_jr_s) begin
            pc_sel = 2'd2;
        end else if (sel_taken_s) begin
            pc_sel = 2'd1;
        end else begin
            pc_sel = 2'd0;
        end
    end

    // State register and memory wait counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= S_IDLE;
            wait_cnt_r <= 8'd0;
        end else begin
            state_r <= next_s;
            if (next_s != state_r) begin
                wait_cnt_r <= 8'd0;
            end else if ((state_r == S_FETCH && !imem_ready) ||
                         (state_r == S_MEM && !dmem_ready)) begin
                wait_cnt_r <= wait_cnt_r + 8'd1;
            end else begin
                wait_cnt_r <= wait_cnt_r;
            end
        end
    end

    // Decoder bits captured in EXEC so MEM and WB never look at the decoder.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken_r      <= 1'b0;
            jr_r         <= 1'b0;
            mem_read_r   <= 1'b0;
            mem_write_r  <= 1'b0;
            mem_to_reg_r <= 1'b0;
        end else if (state_r == S_EXEC) begin
            taken_r      <= (branch && alu_zero) || jump || jump_reg;
            jr_r         <= jump_reg;
            mem_read_r   <= mem_read;
            mem_write_r  <= mem_write;
            mem_to_reg_r <= mem_to_reg;
        end else begin
            taken_r      <= taken_r;
            jr_r         <= jr_r;
            mem_read_r   <= mem_read_r;
            mem_write_r  <= mem_write_r;
            mem_to_reg_r <= mem_to_reg_r;
        end
    end

    // Retired-instruction counter, wraps naturally at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_r <= 32'd0;
        end else if (retire_s) begin
            retired_r <= retired_r + 32'd1;
        end else begin
            retired_r <= retired_r;
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Randomized scoreboard bench for cpu_sequencer: per-instruction expectations are
// derived from instruction class and memory wait counts, then matched at each retire.
module tb_cpu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        imem_ready = 1'b0;
    logic        dmem_ready = 1'b0;
    logic        reg_write = 1'b0, mem_read = 1'b0, mem_write = 1'b0, mem_to_reg = 1'b0;
    logic        branch = 1'b0, jump = 1'b0, jump_reg = 1'b0, illegal = 1'b0, alu_zero = 1'b0;
    logic        imem_req, ir_write, alu_en, dmem_req, dmem_we, rf_write, wb_sel, pc_write, trap;
    logic [1:0]  pc_sel;
    logic [31:0] retired;
    logic [2:0]  state;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int       seq;
        int       cycles;
        int       icyc;
        int       dcyc;
        int       psel;
        bit       rf;
        bit       we;
        bit       wbs;
    } exp_t;

    exp_t exp_q[$];

    cpu_sequencer #(.TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .mem_to_reg(mem_to_reg), .branch(branch), .jump(jump), .jump_reg(jump_reg),
        .illegal(illegal), .alu_zero(alu_zero),
        .imem_req(imem_req), .ir_write(ir_write), .alu_en(alu_en),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .rf_write(rf_write),
        .wb_sel(wb_sel), .pc_write(pc_write), .pc_sel(pc_sel),
        .retired(retired), .state(state), .trap(trap)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Instruction classes: 0 ALU, 1 lw, 2 sw, 3 beq, 4 jal, 5 jalr.
    function automatic exp_t model(input int typ, input int iw, input int dw,
                                   input bit z, input int seq);
        exp_t e;
        bit is_mem;
        is_mem   = (typ == 1) || (typ == 2);
        e.seq    = seq;
        e.rf     = (typ == 0) || (typ == 1) || (typ == 4) || (typ == 5);
        e.we     = (typ == 2);
        e.wbs    = (typ == 1);
        e.icyc   = iw + 1;
        e.dcyc   = is_mem ? dw + 1 : 0;
        e.cycles = e.icyc + 2 + e.dcyc + (e.rf ? 1 : 0);
        if (typ == 5)                  e.psel = 2;
        else if (typ == 4)             e.psel = 1;
        else if (typ == 3 && z)        e.psel = 1;
        else                           e.psel = 0;
        return e;
    endfunction

    task automatic set_dec(input int typ, input bit z);
        reg_write = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_to_reg = 1'b0;
        branch = 1'b0; jump = 1'b0; jump_reg = 1'b0; illegal = 1'b0;
        alu_zero = z;
        case (typ)
            0: reg_write = 1'b1;
            1: begin mem_read = 1'b1; reg_write = 1'b1; mem_to_reg = 1'b1; end
            2: mem_write = 1'b1;
            3: branch = 1'b1;
            4: begin jump = 1'b1; reg_write = 1'b1; end
            5: begin jump_reg = 1'b1; reg_write = 1'b1; end
            default: reg_write = 1'b0;
        endcase
    endtask

    task automatic wait_state(input logic [2:0] s);
        int n = 0;
        while (state !== s && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (state !== s) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_state: got %0d expected %0d (bound expired)", state, s);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
        set_dec(0, 1'b0);
        reg_write = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Monitor: accumulate per-instruction activity and score it at each retire.
    int m_cyc = 0, m_ic = 0, m_dc = 0;
    bit m_rf = 1'b0, m_we = 1'b0, m_wbs = 1'b0;
    always @(negedge clk) begin
        if (!rst_n || state == 3'd0 || state == 3'd6) begin
            m_cyc = 0; m_ic = 0; m_dc = 0; m_rf = 1'b0; m_we = 1'b0; m_wbs = 1'b0;
        end else begin
            m_cyc++;
            if (imem_req) m_ic++;
            if (dmem_req) m_dc++;
            if (dmem_req && dmem_we) m_we = 1'b1;
            if (rf_write) begin m_rf = 1'b1; m_wbs = wb_sel; end
            if (pc_write) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_retire", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("pc_sel", pc_sel, e.psel);
                    chk("cycles", m_cyc, e.cycles);
                    chk("imem_req_cycles", m_ic, e.icyc);
                    chk("dmem_req_cycles", m_dc, e.dcyc);
                    chk("rf_write_seen", m_rf, e.rf);
                    chk("dmem_we_seen", m_we, e.we);
                    if (e.rf) chk("wb_sel", m_wbs, e.wbs);
                    chk("retired_before", retired, e.seq);
                end
                m_cyc = 0; m_ic = 0; m_dc = 0; m_rf = 1'b0; m_we = 1'b0; m_wbs = 1'b0;
            end
        end
    end

    initial begin
        int n;
        int typ, iw, dw;
        bit z;
        repeat (2) @(negedge clk);
        chk("reset_state", state, 0);
        chk("reset_retired", retired, 0);
        chk("reset_strobes", {imem_req, ir_write, alu_en, dmem_req, dmem_we,
                              rf_write, wb_sel, pc_write, pc_sel, trap}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_no_start", state, 0);
        do_start();

        for (int i = 0; i < 40; i++) begin
            typ = $urandom_range(5, 0);
            iw  = $urandom_range(3, 0);
            dw  = $urandom_range(3, 0);
            z   = 1'($urandom_range(1, 0));
            wait_state(3'd1);
            exp_q.push_back(model(typ, iw, dw, z, i));
            imem_ready = 1'b0;
            repeat (iw) begin
                dmem_ready = 1'($urandom_range(1, 0));
                @(negedge clk);
            end
            set_dec(typ, z);
            dmem_ready = 1'b0;
            imem_ready = 1'b1;
            @(negedge clk);
            imem_ready = 1'b0;
            if (typ == 1 || typ == 2) begin
                wait_state(3'd4);
                repeat (dw) @(negedge clk);
                dmem_ready = 1'b1;
                @(negedge clk);
                dmem_ready = 1'b0;
            end
        end

        // Fetch timeout: TIMEOUT=4 gives four FETCH cycles, then sticky TRAP.
        wait_state(3'd1);
        chk("queue_drained", exp_q.size(), 0);
        n = 0;
        while (state == 3'd1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("timeout_fetch_cycles", n, 4);
        chk("timeout_state", state, 6);
        chk("timeout_trap", trap, 1);
        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        chk("trap_sticky_state", state, 6);
        chk("trap_sticky_flag", trap, 1);
        chk("trap_no_req", {imem_req, dmem_req, pc_write}, 0);
        chk("trap_retired", retired, 40);

        // Illegal instruction traps from DECODE without retiring.
        do_reset();
        @(negedge clk);
        do_start();
        wait_state(3'd1);
        set_dec(0, 1'b0);
        illegal = 1'b1;
        imem_ready = 1'b1;
        @(negedge clk);
        imem_ready = 1'b0;
        chk("illegal_decode", state, 2);
        @(negedge clk);
        chk("illegal_state", state, 6);
        chk("illegal_trap", trap, 1);
        chk("illegal_retired", retired, 0);
        illegal = 1'b0;

        // Reset while a data request is outstanding.
        do_reset();
        @(negedge clk);
        do_start();
        wait_state(3'd1);
        set_dec(1, 1'b0);
        imem_ready = 1'b1;
        @(negedge clk);
        imem_ready = 1'b0;
        wait_state(3'd4);
        @(negedge clk);
        chk("mid_mem_req", dmem_req, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("reset_drops_dmem_req", dmem_req, 0);
        chk("reset_mid_mem_state", state, 0);
        chk("reset_mid_mem_retired", retired, 0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("after_reset_idle", state, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
